gen_pipe_adder: RTL and testbench
=================================

Name: gen_pipe_adder

Overview:
- Parametrised, pipelined, registered add/subtract unit; WIDTH-bit carry chain split into CHUNK-bit segments, one pipeline stage per segment.
- Generalises the single-cycle registered ripple-carry adder to configurable width, segment size and pipeline depth.
- Adds an add/subtract mode and a valid/ready handshake with bubble-collapsing backpressure.
- Sits in the generate-construct regression set as a streaming datapath block.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK (derived localparam, >= 1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts beat this cycle
- in_sub  input  1  0 = a+b, 1 = a-b
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result, modulo 2^WIDTH
- out_carry  output  1  raw carry-out of MSB (for sub: 1 = no borrow)

Behaviour:
- Reset: asynchronous on rst_n low; all stage valid bits 0; out_valid=0, out_sum=0, out_carry=0; all data registers 0. in_ready=1 one cycle after rst_n rises, or immediately if combinational from empty state.
- Operand prep at input: b_eff = in_sub ? ~in_b : in_b; carry_in = in_sub.
- Stage k (0..STAGES-1) holds: valid_k; result bits [k*CHUNK+CHUNK-1:0]; registered carry out of segment k; unprocessed upper slices of a and b_eff.
- Stage k computes segment k = a_seg + b_seg + carry from stage k-1 (stage 0 uses carry_in). Chain is purely CHUNK bits wide per stage.
- Output is stage STAGES-1: out_sum = full result, out_carry = its segment carry.
- Latency: a beat accepted at edge N appears at out_valid after edge N+STAGES-1. Example: STAGES=4 and accept at cycle 0 gives out_valid in cycle 3. Throughput is 1 beat per cycle when out_ready=1.
- Stall rule, per stage: load_k = !valid_k || load_{k+1}. For the last stage, load_last = !out_valid || out_ready.
- When load_k is asserted, valid_k takes valid_{k-1}; stage 0 takes in_valid. Data registers load only when the upstream valid bit is 1.
- Bubbles collapse: a stalled output does not block empty upstream stages.
- in_ready = load_0 (combinational from out_ready through the chain).
- Transfer on in_valid&&in_ready; result consumed on out_valid&&out_ready.
- Order is strictly FIFO. Maximum in-flight beats = STAGES. No drop, no duplication.
- Data held stable while out_valid && !out_ready.
- in_valid with in_ready=0: no state change; the source must hold its beat.
- Simultaneous consume and accept while full: both proceed in the same cycle; occupancy unchanged.
- rst_n asserted mid-operation: all in-flight beats discarded immediately; no partial result is emitted after release.
- STAGES=1 (CHUNK=WIDTH): single registered adder, latency 1, same handshake rules.
- Wrap: out_sum modulo 2^WIDTH; overflow is indicated only via out_carry.

Decomposition:
- Shared package gen_pipe_pkg holds:
  - function stages(WIDTH,CHUNK)
  - localparam MODE_ADD=1'b0, MODE_SUB=1'b1
  - typedef of the stage record {valid, carry, sum, a_hi, b_hi}, sized from parameters.
- One sub-module, gen_pipe_seg: CHUNK-bit adder slice plus stage register and load logic. It is instantiated STAGES times in a generate loop, and stage k references stage k-1 through hierarchical generate-block names.

Test Plan:
- WIDTH=16, CHUNK=4: add 0xFFFF+0x0001, out_ready=1 -> out_valid in cycle 3, out_sum=0x0000, out_carry=1.
- Subtract 0x0005-0x0007 -> out_sum=0xFFFE, out_carry=0. Subtract 0x0007-0x0005 -> 0x0002, out_carry=1.
- Throughput: 8 back-to-back beats a=i, b=0x1000*i (i=0..7), out_ready=1 -> 8 consecutive out_valid cycles, in order, sums 0x1001*i.
- Backpressure: out_ready=0, offer 6 beats -> exactly 4 accepted, then in_ready=0. Raise out_ready -> 4 results drain in order, then remaining 2 accepted, latency 4 each.
- Bubble collapse: one beat, stall output 5 cycles, then send 3 beats -> all 3 accepted while stalled (in_ready=1); total order preserved.
- Reset: rst_n low in cycle 2 with 3 beats in flight -> out_valid=0, out_sum=0 immediately, nothing emitted after release. Repeat the add test with CHUNK=16 -> latency 1.

Source files
------------

// File: rtl/gen_pipe_adder_pkg.sv
// Shared definitions for the segmented pipelined add/subtract unit.
// Holds operating-mode encodings and the depth helper.
package gen_pipe_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // One pipeline stage per CHUNK-bit segment; a zero chunk degenerates to one stage.
  function automatic int stages(input int width, input int chunk);
    return (chunk > 0) ? width / chunk : 1;
  endfunction

endpackage

// File: rtl/gen_pipe_adder_if.sv
// Streaming operand/result bundle for gen_pipe_adder.
// The slave modport is the adder side; the master modport is the source/sink side.
interface gen_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sub;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;

  modport master (
    output in_valid, in_sub, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_carry
  );

  modport slave (
    input  in_valid, in_sub, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_carry
  );
endinterface

// File: rtl/gen_pipe_adder_seg.sv
// One CHUNK-bit slice of the carry chain plus its stage register and stall logic.
// Operand fields arrive pre-shifted so the active segment is always in the low CHUNK bits.
module gen_pipe_seg #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load_next,
  input  logic             i_valid,
  input  logic             i_carry,
  input  logic [WIDTH-1:0] i_sum,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_load,
  output logic             o_valid,
  output logic             o_carry,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b
);

  logic [CHUNK:0]   w_seg;
  logic             r_valid;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  assign w_seg  = {1'b0, i_a[CHUNK-1:0]} + {1'b0, i_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, i_carry};
  // An empty stage always accepts, so bubbles are squeezed out behind a stall.
  assign o_load = !r_valid || i_load_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else if (o_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_carry <= w_seg[CHUNK];
        r_sum   <= i_sum | (WIDTH'(w_seg[CHUNK-1:0]) << (IDX * CHUNK));
        r_a     <= i_a >> CHUNK;
        r_b     <= i_b >> CHUNK;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_carry = r_carry;
  assign o_sum   = r_sum;
  assign o_a     = r_a;
  assign o_b     = r_b;

endmodule

// File: rtl/gen_pipe_adder.sv
// Pipelined WIDTH-bit add/subtract unit, one CHUNK-bit carry segment per stage,
// with a valid/ready stream interface and bubble-collapsing backpressure.
module gen_pipe_adder
  import gen_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic              clk,
  input logic              rst_n,
  gen_pipe_adder_if.slave  bus
);

  localparam int STAGES = stages(WIDTH, CHUNK);

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
  } stage_t;

  stage_t w_in;
  logic   w_load_last;
  logic   w_unused_hi;

  // Subtraction is a + ~b + 1, with the +1 fed in as the chain's carry-in.
  always_comb begin
    w_in       = '0;
    w_in.valid = bus.in_valid;
    w_in.carry = (bus.in_sub == MODE_SUB);
    w_in.a_hi  = bus.in_a;
    w_in.b_hi  = (bus.in_sub == MODE_SUB) ? ~bus.in_b : bus.in_b;
  end

  assign w_load_last = !bus.out_valid || bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           w_prev;
    logic             w_load_next;
    logic             w_load;
    logic             w_valid;
    logic             w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    if (k == 0) begin : g_src_in
      assign w_prev = w_in;
    end else begin : g_src_prev
      assign w_prev = '{valid: g_stage[k-1].w_valid, carry: g_stage[k-1].w_carry,
                        sum:   g_stage[k-1].w_sum,   a_hi:  g_stage[k-1].w_a,
                        b_hi:  g_stage[k-1].w_b};
    end

    if (k == STAGES - 1) begin : g_ld_out
      assign w_load_next = w_load_last;
    end else begin : g_ld_next
      assign w_load_next = g_stage[k+1].w_load;
    end

    gen_pipe_seg #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_seg (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load_next (w_load_next),
      .i_valid     (w_prev.valid),
      .i_carry     (w_prev.carry),
      .i_sum       (w_prev.sum),
      .i_a         (w_prev.a_hi),
      .i_b         (w_prev.b_hi),
      .o_load      (w_load),
      .o_valid     (w_valid),
      .o_carry     (w_carry),
      .o_sum       (w_sum),
      .o_a         (w_a),
      .o_b         (w_b)
    );
  end

  assign bus.in_ready  = g_stage[0].w_load;
  assign bus.out_valid = g_stage[STAGES-1].w_valid;
  assign bus.out_sum   = g_stage[STAGES-1].w_sum;
  assign bus.out_carry = g_stage[STAGES-1].w_carry;

  // Operand remainders leaving the last stage are always exhausted.
  assign w_unused_hi = ^{g_stage[STAGES-1].w_a, g_stage[STAGES-1].w_b};

endmodule

// File: tb/tb_gen_pipe_adder.sv
// Bench for gen_pipe_adder: scoreboard against an arithmetic model plus directed scenarios.
module tb_gen_pipe_adder;

  localparam int W = 16;
  localparam int ST = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  res_t         exp_q[$];
  logic [W-1:0] got_q[$];
  int           got_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gen_pipe_adder_if #(.WIDTH(W)) bus0 ();
  gen_pipe_adder_if #(.WIDTH(W)) bus1 ();

  gen_pipe_adder #(.WIDTH(W), .CHUNK(4))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus0));
  gen_pipe_adder #(.WIDTH(W), .CHUNK(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    res_t        r;
    int unsigned av = 32'(a);
    int unsigned bv = 32'(b);
    if (sub) begin
      r.sum   = W'(av - bv);
      r.carry = (av >= bv);
    end else begin
      r.sum   = W'(av + bv);
      r.carry = ((av + bv) >= 32'h10000);
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Scoreboard: occupancy-derived ready, head-of-queue result on every valid cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      chk("in_ready_model", 32'(bus0.in_ready),
          32'((exp_q.size() < ST) || bus0.out_ready));
      if (exp_q.size() > ST) begin
        tests++;
        fails++;
        $display("FAIL inflight: %0d beats outstanding, limit %0d", exp_q.size(), ST);
      end
      if (bus0.out_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_out: out_valid=1 sum=0x%0h with no beat outstanding",
                   bus0.out_sum);
        end else begin
          chk("sb_sum", 32'(bus0.out_sum), 32'(exp_q[0].sum));
          chk("sb_carry", 32'(bus0.out_carry), 32'(exp_q[0].carry));
          if (bus0.out_ready) begin
            void'(exp_q.pop_front());
            got_q.push_back(bus0.out_sum);
            got_cyc.push_back(cyc);
          end
        end
      end
      if (bus0.in_valid && bus0.in_ready)
        exp_q.push_back(model(bus0.in_a, bus0.in_b, bus0.in_sub));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                      output int waited);
    logic ok;
    bus0.in_valid = 1'b1;
    bus0.in_a     = a;
    bus0.in_b     = b;
    bus0.in_sub   = sub;
    waited        = 0;
    forever begin
      @(negedge clk);
      ok = bus0.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      waited++;
      if (waited > 100) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: beat a=0x%0h not accepted within 100 cycles", a);
        break;
      end
    end
    bus0.in_valid = 1'b0;
  endtask

  task automatic lat_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output int n, output logic [W-1:0] s, output logic c);
    int w;
    send(a, b, sub, w);
    n = 0;
    while (!bus0.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    s = bus0.out_sum;
    c = bus0.out_carry;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int           n, w, idx, base, g;
    logic         ok;
    logic [W-1:0] s;
    logic         c;
    logic [W-1:0] bp_exp[6];
    logic [W-1:0] bub_exp[4];

    bus0.in_valid = 0; bus0.in_sub = 0; bus0.in_a = '0; bus0.in_b = '0; bus0.out_ready = 1;
    bus1.in_valid = 0; bus1.in_sub = 0; bus1.in_a = '0; bus1.in_b = '0; bus1.out_ready = 1;

    // Model pinned against hand-computed values
    chk("model_add_wrap", 32'(model(16'hFFFF, 16'h0001, 1'b0).sum), 32'h0);
    chk("model_add_cy", 32'(model(16'hFFFF, 16'h0001, 1'b0).carry), 32'h1);
    chk("model_sub_neg", 32'(model(16'h0005, 16'h0007, 1'b1).sum), 32'hFFFE);
    chk("model_sub_eq_cy", 32'(model(16'h1234, 16'h1234, 1'b1).carry), 32'h1);

    idle(2);
    chk("rst_out_valid", 32'(bus0.out_valid), 0);
    chk("rst_out_sum", 32'(bus0.out_sum), 0);
    chk("rst_out_carry", 32'(bus0.out_carry), 0);
    chk("rst_c16_out_valid", 32'(bus1.out_valid), 0);
    rst_n = 1'b1;
    idle(1);
    chk("rst_in_ready", 32'(bus0.in_ready), 1);

    lat_one(16'hFFFF, 16'h0001, 1'b0, n, s, c);
    chk("add_latency", 32'(n), 3);
    chk("add_sum", 32'(s), 32'h0000);
    chk("add_carry", 32'(c), 1);
    lat_one(16'h0005, 16'h0007, 1'b1, n, s, c);
    chk("sub_neg_sum", 32'(s), 32'hFFFE);
    chk("sub_neg_carry", 32'(c), 0);
    lat_one(16'h0007, 16'h0005, 1'b1, n, s, c);
    chk("sub_pos_sum", 32'(s), 32'h0002);
    chk("sub_pos_carry", 32'(c), 1);

    // Back-to-back throughput
    base = got_q.size();
    for (int i = 0; i < 8; i++) begin
      send(W'(i), W'(16'h1000 * i), 1'b0, w);
      chk("tput_wait", 32'(w), 0);
    end
    idle(8);
    chk("tput_count", 32'(got_q.size() - base), 8);
    for (int i = 0; i < 8 && base + i < got_q.size(); i++) begin
      chk("tput_sum", 32'(got_q[base+i]), 32'(16'h1001 * i));
      chk("tput_consec", 32'(got_cyc[base+i] - got_cyc[base]), 32'(i));
    end

    // Backpressure: six beats offered into a stalled pipe
    base = got_q.size();
    bus0.out_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      if (idx < 6) begin
        bus0.in_valid = 1'b1; bus0.in_a = W'(16'h100 + idx); bus0.in_b = W'(idx); bus0.in_sub = 0;
      end else bus0.in_valid = 1'b0;
      @(negedge clk);
      ok = bus0.in_valid && bus0.in_ready;
      @(posedge clk);
      #1;
      if (ok) idx++;
    end
    chk("bp_accepted", 32'(idx), 4);
    chk("bp_in_ready", 32'(bus0.in_ready), 0);
    bus0.out_ready = 1'b1;
    for (int k = 0; k < 50 && idx < 6; k++) begin
      bus0.in_valid = 1'b1; bus0.in_a = W'(16'h100 + idx); bus0.in_b = W'(idx); bus0.in_sub = 0;
      @(negedge clk);
      ok = bus0.in_ready;
      @(posedge clk);
      #1;
      if (ok) idx++;
    end
    bus0.in_valid = 1'b0;
    idle(10);
    bp_exp = '{16'h100, 16'h102, 16'h104, 16'h106, 16'h108, 16'h10A};
    chk("bp_count", 32'(got_q.size() - base), 6);
    for (int i = 0; i < 6 && base + i < got_q.size(); i++)
      chk("bp_order", 32'(got_q[base+i]), 32'(bp_exp[i]));

    // Bubble collapse behind a stalled output
    base = got_q.size();
    bus0.out_ready = 1'b0;
    send(16'h000A, 16'h000B, 1'b0, w);
    idle(5);
    send(16'h0100, 16'h0001, 1'b0, w); chk("bubble_wait0", 32'(w), 0);
    send(16'h0200, 16'h0002, 1'b1, w); chk("bubble_wait1", 32'(w), 0);
    send(16'hFFF0, 16'h0020, 1'b0, w); chk("bubble_wait2", 32'(w), 0);
    bus0.out_ready = 1'b1;
    idle(10);
    bub_exp = '{16'h0015, 16'h0101, 16'h01FE, 16'h0010};
    chk("bubble_count", 32'(got_q.size() - base), 4);
    for (int i = 0; i < 4 && base + i < got_q.size(); i++)
      chk("bubble_order", 32'(got_q[base+i]), 32'(bub_exp[i]));

    // Reset with three beats in flight
    send(16'h0011, 16'h0001, 1'b0, w);
    send(16'h0022, 16'h0002, 1'b0, w);
    send(16'h0033, 16'h0003, 1'b0, w);
    g = got_q.size();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus0.out_valid), 0);
    chk("midrst_out_sum", 32'(bus0.out_sum), 0);
    chk("midrst_out_carry", 32'(bus0.out_carry), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle(10);
    chk("midrst_no_emit", 32'(got_q.size()), 32'(g));

    // Randomized traffic with random backpressure
    begin
      logic acc = 1'b0;
      for (int k = 0; k < 400; k++) begin
        if (!bus0.in_valid || acc) begin
          bus0.in_valid = ($urandom_range(0, 3) != 0);
          case ($urandom_range(0, 3))
            0:       bus0.in_a = 16'hFFFF;
            1:       bus0.in_a = 16'h0000;
            default: bus0.in_a = W'($urandom);
          endcase
          bus0.in_b   = W'($urandom);
          bus0.in_sub = 1'($urandom);
        end
        bus0.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        acc = bus0.in_valid && bus0.in_ready;
        @(posedge clk);
        #1;
      end
      bus0.in_valid  = 1'b0;
      bus0.out_ready = 1'b1;
      idle(20);
      chk("rand_drained", 32'(exp_q.size()), 0);
    end

    // Single-stage build: one registered adder
    bus1.in_valid = 1'b1; bus1.in_a = 16'hFFFF; bus1.in_b = 16'h0001; bus1.in_sub = 1'b0;
    @(negedge clk);
    ok = bus1.in_ready;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    n = 0;
    while (!bus1.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("c16_accept", 32'(ok), 1);
    chk("c16_latency", 32'(n), 0);
    chk("c16_sum", 32'(bus1.out_sum), 0);
    chk("c16_carry", 32'(bus1.out_carry), 1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
